// File: rtl/rsfq_dec_pkg.sv
// Shared types and helpers for the RSFQ toggle-encoded output decoder.
package rsfq_dec_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    WINDOW = 1'b1
  } dec_state_t;

  localparam int ERR_ORPHAN   = 0;
  localparam int ERR_DOUBLE   = 1;
  localparam int ERR_OVERFLOW = 2;
  localparam int ERR_X        = 3;
  localparam int ERR_NUM      = 4;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rsfq_toggle_sync.sv
// Synchronizer plus toggle-change detector: one-cycle pulse per edge of din,
// SYNC_STAGES+1 cycles after the input changes. hold freezes the first stage.
module rsfq_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic hold,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   hist_p;
  logic                   pulse_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p  <= '0;
      hist_p  <= 1'b0;
      pulse_p <= 1'b0;
    end else begin
      sync_p  <= {sync_p[SYNC_STAGES-2:0], hold ? sync_p[0] : din};
      // edge detect stage: any change of the synchronized level is one pulse
      hist_p  <= sync_p[SYNC_STAGES-1];
      pulse_p <= sync_p[SYNC_STAGES-1] ^ hist_p;
    end
  end

  assign pulse = pulse_p;

endmodule

// File: rtl/rsfq_toggle_decoder.sv
// Decodes a toggle-encoded RSFQ gate output into WORD_W-bit words, one bit per
// RSFQ clock window. Optional X detection on sfq_q: define RSFQ_DEC_XCHECK_EN.
module rsfq_toggle_decoder
  import rsfq_dec_pkg::*;
#(
  parameter int WORD_W      = 8,
  parameter int LAT_MAX     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sfq_clk,
  input  logic              sfq_q,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              err_clear,
  output logic              err_orphan,
  output logic              err_double,
  output logic              err_overflow,
  output logic              err_x
);

  localparam int LW = cnt_w(LAT_MAX);
  localparam int BW = cnt_w(WORD_W - 1);

  logic clk_ev, q_ev, q_hold;

`ifdef RSFQ_DEC_XCHECK_EN
  logic q_x;
  assign q_x    = (sfq_q !== 1'b0) && (sfq_q !== 1'b1);
  assign q_hold = q_x;
`else
  assign q_hold = 1'b0;
`endif

  rsfq_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk(clk), .rst_n(rst_n), .din(sfq_clk), .hold(1'b0), .pulse(clk_ev)
  );

  rsfq_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_q_sync (
    .clk(clk), .rst_n(rst_n), .din(sfq_q), .hold(q_hold), .pulse(q_ev)
  );

  dec_state_t          state, state_n;
  logic [LW-1:0]       lat_cnt, lat_n, lat_inc;
  logic                q_seen, qs_n, seen;
  logic [BW-1:0]       bit_cnt, bit_n;
  logic [WORD_W-1:0]   sreg, sreg_n, word_cur, data_n;
  logic                valid_n;
  logic [ERR_NUM-1:0]  err_q, err_set, err_n;
  logic                commit, commit_bit, complete, load;

  always_comb begin
    state_n    = state;
    lat_n      = lat_cnt;
    qs_n       = q_seen;
    bit_n      = bit_cnt;
    sreg_n     = sreg;
    commit     = 1'b0;
    commit_bit = 1'b0;
    complete   = 1'b0;
    err_set    = '0;
    seen       = q_seen | q_ev;
    lat_inc    = lat_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (q_ev) err_set[ERR_ORPHAN] = 1'b1;
        if (clk_ev) begin
          state_n = WINDOW;
          lat_n   = '0;
          qs_n    = 1'b0;
        end
      end
      WINDOW: begin
        if (q_ev && q_seen) err_set[ERR_DOUBLE] = 1'b1;
        // a q pulse coincident with the closing clk belongs to the old window
        if (clk_ev) begin
          commit     = 1'b1;
          commit_bit = seen;
          lat_n      = '0;
          qs_n       = 1'b0;
        end else if (lat_inc == LW'(LAT_MAX)) begin
          commit     = 1'b1;
          commit_bit = seen;
          state_n    = IDLE;
          lat_n      = '0;
          qs_n       = 1'b0;
        end else begin
          lat_n = lat_inc;
          qs_n  = seen;
        end
      end
      default: state_n = IDLE;
    endcase

    word_cur = sreg;
    for (int i = 0; i < WORD_W; i++) begin
      if (int'(bit_cnt) == i) word_cur[i] = commit_bit;
    end

    if (commit) begin
      sreg_n = word_cur;
      if (bit_cnt == BW'(WORD_W - 1)) begin
        bit_n    = '0;
        complete = 1'b1;
      end else begin
        bit_n = bit_cnt + 1'b1;
      end
    end

    // a finished word replaces the held one only if the consumer takes it now
    load    = complete && (!out_valid || out_ready);
    data_n  = load ? word_cur : out_data;
    valid_n = load ? 1'b1 : ((out_valid && out_ready) ? 1'b0 : out_valid);
    if (complete && out_valid && !out_ready) err_set[ERR_OVERFLOW] = 1'b1;

`ifdef RSFQ_DEC_XCHECK_EN
    if (q_x) err_set[ERR_X] = 1'b1;
`endif

    err_n = (err_clear ? '0 : err_q) | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      q_seen    <= 1'b0;
      bit_cnt   <= '0;
      sreg      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err_q     <= '0;
    end else begin
      state     <= state_n;
      lat_cnt   <= lat_n;
      q_seen    <= qs_n;
      bit_cnt   <= bit_n;
      sreg      <= sreg_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      err_q     <= err_n;
    end
  end

  assign err_orphan   = err_q[ERR_ORPHAN];
  assign err_double   = err_q[ERR_DOUBLE];
  assign err_overflow = err_q[ERR_OVERFLOW];
  assign err_x        = err_q[ERR_X];

endmodule

// File: tb/tb_rsfq_toggle_decoder.sv
// Randomized bench for rsfq_toggle_decoder with a window-assignment reference model.
`timescale 1ns/1ps
module tb_rsfq_toggle_decoder;

  localparam int WORD_W  = 8;
  localparam int LAT_MAX = 4;
  localparam int SYNC    = 2;
  localparam int MAXC    = 320;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sfq_clk = 1'b0;
  logic              sfq_q = 1'b0;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              err_clear = 1'b0;
  logic              err_orphan, err_double, err_overflow, err_x;

  int n_checks = 0;
  int n_fail   = 0;

  bit        clk_s[MAXC];
  bit        q_s[MAXC];
  bit        exp_bits[$];
  logic [7:0] expw[$];
  logic [7:0] got[$];
  int        m_orphan;
  bit        m_double;

  rsfq_toggle_decoder #(.WORD_W(WORD_W), .LAT_MAX(LAT_MAX), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .sfq_clk(sfq_clk), .sfq_q(sfq_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_clear(err_clear), .err_orphan(err_orphan), .err_double(err_double),
    .err_overflow(err_overflow), .err_x(err_x)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic clr_sched();
    for (int i = 0; i < MAXC; i++) begin
      clk_s[i] = 1'b0;
      q_s[i]   = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sfq_clk = 1'b0; sfq_q = 1'b0; err_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    got.delete();
  endtask

  task automatic play(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
      if (clk_s[t]) sfq_clk = ~sfq_clk;
      if (q_s[t])   sfq_q   = ~sfq_q;
    end
    repeat (SYNC + LAT_MAX + 8) @(posedge clk);
    @(negedge clk);
  endtask

  // A q toggle belongs to the most recent earlier clk toggle if it lies within
  // LAT_MAX cycles of it; otherwise it is an orphan. One bit per clk toggle.
  task automatic model(input int n);
    int  last_c, cnt;
    bit  open;
    logic [7:0] v;
    exp_bits.delete(); expw.delete();
    m_orphan = 0; m_double = 1'b0; open = 1'b0; last_c = 0; cnt = 0;
    for (int t = 0; t < n; t++) begin
      if (q_s[t]) begin
        if (open && (t - last_c) <= LAT_MAX) begin
          cnt++;
          if (cnt > 1) m_double = 1'b1;
        end else m_orphan++;
      end
      if (clk_s[t]) begin
        if (open) exp_bits.push_back(cnt > 0);
        open = 1'b1; last_c = t; cnt = 0;
      end
    end
    if (open) exp_bits.push_back(cnt > 0);
    for (int w = 0; w < exp_bits.size() / 8; w++) begin
      for (int b = 0; b < 8; b++) v[b] = exp_bits[w*8 + b];
      expw.push_back(v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_data} !== 9'h0) begin
      n_fail++; $display("FAIL reset_out: got valid=%b data=%h expected 0/00", out_valid, out_data);
    end
    n_checks++;
    if ({err_orphan, err_double, err_overflow, err_x} !== 4'b0) begin
      n_fail++; $display("FAIL reset_err: got %b%b%b%b expected 0000", err_orphan, err_double, err_overflow, err_x);
    end
    do_reset();
  endtask

  task automatic test_basic_word();
    do_reset();
    clr_sched();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      clk_s[5 + 10*k] = 1'b1;
      if (k == 0 || k == 2 || k == 3 || k == 7) q_s[7 + 10*k] = 1'b1;
    end
    play(90);
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h8D) begin
      n_fail++; $display("FAIL basic_hold: got valid=%b data=%h expected 1/8d", out_valid, out_data);
    end
    n_checks++;
    if ({err_orphan, err_double, err_overflow} !== 3'b0) begin
      n_fail++; $display("FAIL basic_err: got %b%b%b expected 000", err_orphan, err_double, err_overflow);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (got.size() != 1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_accept: got %0d words valid=%b expected 1 word valid=0", got.size(), out_valid);
    end else begin
      n_checks++;
      if (got[0] !== 8'h8D) begin
        n_fail++; $display("FAIL basic_word: got %h expected 8d", got[0]);
      end
    end
  endtask

  task automatic test_orphan();
    do_reset();
    clr_sched();
    out_ready = 1'b1;
    q_s[3] = 1'b1;
    for (int k = 0; k < 8; k++) clk_s[20 + 10*k] = 1'b1;
    q_s[22] = 1'b1;
    play(100);
    model(100);
    n_checks++;
    if (err_orphan !== (m_orphan > 0)) begin
      n_fail++; $display("FAIL orphan_flag: got %b expected %b", err_orphan, m_orphan > 0);
    end
    n_checks++;
    if (got.size() != 1 || expw.size() != 1) begin
      n_fail++; $display("FAIL orphan_words: got %0d words expected %0d", got.size(), expw.size());
    end else begin
      n_checks++;
      if (got[0] !== expw[0]) begin
        n_fail++; $display("FAIL orphan_word: got %h expected %h", got[0], expw[0]);
      end
    end
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_orphan !== 1'b0) begin
      n_fail++; $display("FAIL orphan_clear: got %b expected 0", err_orphan);
    end
  endtask

  task automatic test_double();
    do_reset();
    clr_sched();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) clk_s[5 + 10*k] = 1'b1;
    q_s[6] = 1'b1;
    q_s[7] = 1'b1;
    play(90);
    n_checks++;
    if (err_double !== 1'b1 || err_orphan !== 1'b0) begin
      n_fail++; $display("FAIL double_flag: got double=%b orphan=%b expected 1/0", err_double, err_orphan);
    end
    n_checks++;
    if (got.size() != 1) begin
      n_fail++; $display("FAIL double_words: got %0d words expected 1", got.size());
    end else begin
      n_checks++;
      if (got[0] !== 8'h01) begin
        n_fail++; $display("FAIL double_word: got %h expected 01", got[0]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    clr_sched();
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      clk_s[10 + 6*k] = 1'b1;
      q_s[11 + 6*k]   = 1'b1;
    end
    play(110);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hFF || err_overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_hold: got valid=%b data=%h ovf=%b expected 1/ff/1", out_valid, out_data, err_overflow);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (got.size() != 1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL overflow_xfer: got %0d words valid=%b expected 1 word valid=0", got.size(), out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    clr_sched();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      clk_s[10 + 2*k] = 1'b1;
      q_s[11 + 2*k]   = 1'b1;
    end
    play(30);
    n_checks++;
    if (got.size() != 1) begin
      n_fail++; $display("FAIL fast_words: got %0d words expected 1", got.size());
    end else begin
      n_checks++;
      if (got[0] !== 8'hFF) begin
        n_fail++; $display("FAIL fast_word: got %h expected ff", got[0]);
      end
    end
    n_checks++;
    if (err_double !== 1'b0 || err_orphan !== 1'b0) begin
      n_fail++; $display("FAIL fast_err: got double=%b orphan=%b expected 0/0", err_double, err_orphan);
    end
  endtask

  task automatic build_random_words(input int nwin, input int start);
    int t, sp, off;
    clr_sched();
    t = start;
    for (int k = 0; k < nwin; k++) begin
      sp = $urandom_range(10, 3);
      clk_s[t] = 1'b1;
      if ($urandom_range(1, 0) == 1) begin
        off = $urandom_range((sp < LAT_MAX) ? sp : LAT_MAX, 1);
        q_s[t + off] = 1'b1;
      end
      t += sp;
    end
  endtask

  task automatic test_random_words();
    do_reset();
    out_ready = 1'b1;
    build_random_words(24, 5);
    play(260);
    model(260);
    n_checks++;
    if (got.size() != expw.size()) begin
      n_fail++; $display("FAIL rwords_count: got %0d expected %0d", got.size(), expw.size());
    end
    for (int i = 0; i < got.size() && i < expw.size(); i++) begin
      n_checks++;
      if (got[i] !== expw[i]) begin
        n_fail++; $display("FAIL rwords_word%0d: got %h expected %h", i, got[i], expw[i]);
      end
    end
    n_checks++;
    if ({err_orphan, err_double, err_overflow} !== 3'b0) begin
      n_fail++; $display("FAIL rwords_err: got %b%b%b expected 000", err_orphan, err_double, err_overflow);
    end
  endtask

  task automatic test_random_mixed();
    do_reset();
    out_ready = 1'b1;
    clr_sched();
    for (int t = 0; t < 300; t++) begin
      clk_s[t] = ($urandom_range(4, 0) == 0);
      q_s[t]   = ($urandom_range(3, 0) == 0);
    end
    play(300);
    model(300);
    n_checks++;
    if (got.size() != expw.size()) begin
      n_fail++; $display("FAIL mixed_count: got %0d expected %0d", got.size(), expw.size());
    end
    for (int i = 0; i < got.size() && i < expw.size(); i++) begin
      n_checks++;
      if (got[i] !== expw[i]) begin
        n_fail++; $display("FAIL mixed_word%0d: got %h expected %h", i, got[i], expw[i]);
      end
    end
    n_checks++;
    if (err_orphan !== (m_orphan > 0) || err_double !== m_double || err_overflow !== 1'b0) begin
      n_fail++; $display("FAIL mixed_err: got o=%b d=%b v=%b expected o=%b d=%b v=0",
                         err_orphan, err_double, err_overflow, m_orphan > 0, m_double);
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    clr_sched();
    out_ready = 1'b0;
    q_s[3] = 1'b1;
    for (int k = 0; k < 13; k++) begin
      clk_s[10 + 6*k] = 1'b1;
      q_s[11 + 6*k]   = 1'b1;
    end
    play(90);
    n_checks++;
    if (out_valid !== 1'b1 || err_orphan !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre: got valid=%b orphan=%b expected 1/1", out_valid, err_orphan);
    end
    @(posedge clk); #3;
    rst_n = 1'b0; sfq_clk = 1'b0; sfq_q = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || err_orphan !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: got valid=%b data=%h orphan=%b expected 0/00/0", out_valid, out_data, err_orphan);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    got.delete();
    out_ready = 1'b1;
    build_random_words(8, 5);
    play(90);
    model(90);
    n_checks++;
    if (got.size() != 1 || expw.size() != 1) begin
      n_fail++; $display("FAIL midrst_words: got %0d words expected %0d", got.size(), expw.size());
    end else begin
      n_checks++;
      if (got[0] !== expw[0]) begin
        n_fail++; $display("FAIL midrst_word: got %h expected %h", got[0], expw[0]);
      end
    end
  endtask

`ifdef RSFQ_DEC_XCHECK_EN
  task automatic test_xcheck();
    do_reset();
    @(posedge clk); #1 sfq_q = 1'bx;
    @(posedge clk); #1 sfq_q = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (err_x !== 1'b1 || err_orphan !== 1'b0) begin
      n_fail++; $display("FAIL xcheck: got x=%b orphan=%b expected 1/0", err_x, err_orphan);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_word();
    test_orphan();
    test_double();
    test_overflow();
    test_back_to_back();
    test_random_words();
    test_random_mixed();
    test_reset_mid_word();
`ifdef RSFQ_DEC_XCHECK_EN
    test_xcheck();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rsfq_toggle_decoder.md
Name: rsfq_toggle_decoder

Overview:
- Downstream consumer of a clocked RSFQ gate model (e.g. clocked XOR) that uses toggle encoding: every edge of a wire is one SFQ pulse.
- Samples the gate's RSFQ clock line and output line in a conventional digital clock domain.
- Assigns each output pulse to the RSFQ clock window that produced it, and packs one bit per window into parallel words.
- Delivers words on a valid/ready interface and flags protocol violations: orphan pulses, double pulses, and X on the output.

Parameters:
- WORD_W, 8, bits per output word (>=2).
- LAT_MAX, 4, sampling cycles after an RSFQ clock event during which an output pulse belongs to that window (1..15).
- SYNC_STAGES, 2, synchronizer flops per toggle input (>=2).

Ports:
- clk  input  1  sampling clock; must be at least 2x faster than the minimum SFQ pulse spacing.
- rst_n  input  1  asynchronous active-low reset.
- sfq_clk  input  1  toggle-encoded RSFQ clock driving the upstream gate.
- sfq_q  input  1  toggle-encoded output of the upstream gate.
- out_data  output  WORD_W  decoded word; first window in bit 0.
- out_valid  output  1  out_data holds an unaccepted word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- err_clear  input  1  synchronous clear of all sticky error flags.
- err_orphan  output  1  sticky: sfq_q pulse with no open window.
- err_double  output  1  sticky: second sfq_q pulse in one window.
- err_overflow  output  1  sticky: word completed while the previous word was unaccepted.
- err_x  output  1  sticky: X/Z seen on sfq_q (only with the optional feature).

Behaviour:
- Reset (async assert, sync release):
  - All synchronizers and edge-detect history go to 0.
  - FSM goes to IDLE; bit count, latency count and shift register clear.
  - out_data=0, out_valid=0, all err_* = 0.
- Edge detect:
  - An event on an input is a change in its synchronized value between consecutive cycles; either edge polarity is one pulse.
  - Input-to-event latency is SYNC_STAGES+1 cycles.
- FSM IDLE:
  - clk event → WINDOW; lat_cnt=0, q_seen=0.
  - q event → set err_orphan.
  - Simultaneous clk+q events → err_orphan, and the window still opens with q_seen=0.
- FSM WINDOW:
  - Each cycle lat_cnt increments.
  - q event with q_seen=0 → q_seen=1; q event with q_seen=1 → set err_double, q_seen stays 1.
  - Window closes on the cycle lat_cnt reaches LAT_MAX, or on a new clk event, whichever comes first.
  - On close, commit bit = q_seen into shift position bit_cnt, bit_cnt++.
  - Close by lat_cnt → IDLE. Close by clk event → new window opens in the same cycle (WINDOW, lat_cnt=0, q_seen=0).
  - A q event coincident with a closing clk event counts toward the closing window; the upstream gate delay is always >0.
- Word completion (bit_cnt reaches WORD_W on a commit):
  - bit_cnt wraps to 0.
  - If out_valid=0, or out_ready=1 this cycle: load out_data, out_valid=1 next cycle.
  - Otherwise: drop the new word, keep the old one, set err_overflow.
- Handshake:
  - out_valid deasserts the cycle after acceptance unless a new word loads in the same cycle.
  - out_data is stable while out_valid && !out_ready.
- err_clear:
  - Clears all err_* flags.
  - A simultaneous new error wins (flag stays 1).
- Reset mid-word discards partial bits. No recovery of a partial word.

Optional Feature:
- Macro: RSFQ_DEC_XCHECK_EN.
- Defined:
  - Raw sfq_q is checked each clk with a 4-state compare.
  - X/Z sets err_x.
  - The X sample is treated as "no change" for edge detection, so the synchronizer holds its last known value.
- Undefined: err_x tied to 0 and no 4-state logic is compiled; the block is synthesizable.

Decomposition:
- Package rsfq_dec_pkg:
  - FSM state enum (IDLE, WINDOW).
  - Error-flag index constants.
  - Width function for lat_cnt and bit_cnt ($clog2).
- Sub-module rsfq_toggle_sync: SYNC_STAGES synchronizer plus toggle-change detector with a one-cycle event pulse output. Instantiated twice, for sfq_clk and sfq_q.

Test Plan:
- WORD_W=8, LAT_MAX=4. Send 8 sfq_clk toggles 10 cycles apart; toggle sfq_q 2 cycles after clocks 0, 2, 3, 7 → one word 0x8D, out_valid held until out_ready; no errors.
- sfq_q toggle with no preceding sfq_clk → err_orphan=1, no bit committed. Then err_clear → err_orphan=0.
- Two sfq_q toggles 1 cycle apart inside one window → err_double=1, committed bit=1.
- Hold out_ready=0 across 16 windows of all-1 data → first word 0xFF kept, err_overflow=1. After out_ready=1, exactly one word is transferred.
- sfq_clk toggles every 2 cycles (shorter than LAT_MAX) with sfq_q toggling 1 cycle after each → each window closes on the next clk, word 0xFF, no err_double.
- Assert rst_n low after 5 bits committed → all outputs 0 asynchronously. The next 8 windows form a fresh word.
- With RSFQ_DEC_XCHECK_EN defined, drive sfq_q=X for 1 cycle → err_x=1, and no false q event is detected.
